// File: rtl/gpu_command_decoder.sv
`timescale 1ns/1ps
// Byte-stream command decoder for the VGA GPU: assembles variable-length commands from
// host bytes and drives mode strobes, handshaked pixel writes and rectangle fills.
module gpu_command_decoder #(
   parameter int X_W     = 10,
   parameter int Y_W     = 10,
   parameter int COLOR_W = 12,
   parameter int MODE_W  = 8
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_en,
   input  logic               i_we,
   input  logic [7:0]         i_data,
   output logic               o_ack,
   output logic               o_busy,
   output logic               o_drop,
   output logic               o_error,
   output logic [MODE_W-1:0]  o_mode,
   output logic               o_set_mode,
   output logic [X_W-1:0]     o_pixel_x,
   output logic [Y_W-1:0]     o_pixel_y,
   output logic [COLOR_W-1:0] o_color,
   output logic               o_set_pixel,
   input  logic               i_pixel_ready
);

   typedef enum logic [1:0] {IDLE, ARGS, EXEC, FILL} state_t;

   localparam logic [7:0] OP_NOOP         = 8'h00;
   localparam logic [7:0] OP_SET_MODE     = 8'h01;
   localparam logic [7:0] OP_SET_BG_COLOR = 8'h02;
   localparam logic [7:0] OP_SET_PIXEL    = 8'h03;
   localparam logic [7:0] OP_FILL_RECT    = 8'h04;

   state_t               state_q;
   logic [7:0]           op_q;
   logic [3:0]           cnt_q;
   logic [7:0]           args_q [10];
   logic                 ack_q;
   logic                 busy_q;
   logic                 drop_q;
   logic                 error_q;
   logic                 set_mode_q;
   logic                 set_pixel_q;
   logic [MODE_W-1:0]    mode_q;
   logic [X_W-1:0]       pix_x_q;
   logic [Y_W-1:0]       pix_y_q;
   logic [COLOR_W-1:0]   color_q;

   logic                 offer;
   logic                 accept;
   logic [X_W-1:0]       x0_w;
   logic [X_W-1:0]       x1_w;
   logic [Y_W-1:0]       y0_w;
   logic [Y_W-1:0]       y1_w;
   logic [COLOR_W-1:0]   bg_color_w;
   logic [COLOR_W-1:0]   px_color_w;
   logic [COLOR_W-1:0]   fill_color_w;
   logic                 fill_empty_w;
   logic                 fill_last_w;
   logic [X_W-1:0]       pix_x_d;
   logic [Y_W-1:0]       pix_y_d;

   function automatic logic [3:0] arg_len(input logic [7:0] op);
      case (op)
         OP_SET_MODE:     return 4'd1;
         OP_SET_BG_COLOR: return 4'd2;
         OP_SET_PIXEL:    return 4'd6;
         OP_FILL_RECT:    return 4'd10;
         default:         return 4'd0;
      endcase
   endfunction

   assign offer  = i_en && i_we;
   assign accept = offer && !busy_q;

   // Little-endian 16-bit arguments, truncated to the field widths (low bits kept).
   assign x0_w         = X_W'({args_q[1], args_q[0]});
   assign y0_w         = Y_W'({args_q[3], args_q[2]});
   assign x1_w         = X_W'({args_q[5], args_q[4]});
   assign y1_w         = Y_W'({args_q[7], args_q[6]});
   assign bg_color_w   = COLOR_W'({args_q[1], args_q[0]});
   assign px_color_w   = COLOR_W'({args_q[5], args_q[4]});
   assign fill_color_w = COLOR_W'({args_q[9], args_q[8]});
   assign fill_empty_w = (x1_w < x0_w) || (y1_w < y0_w);

   // End of fill is found by equality with the far corner, so x1 = 2^X_W-1 is safe.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value unassigned,
      // which would otherwise infer a latch.
      pix_x_d     = pix_x_q + 1'b1;
      pix_y_d     = pix_y_q;
      fill_last_w = (pix_x_q == x1_w) && (pix_y_q == y1_w);
      if (pix_x_q == x1_w) begin
         pix_x_d = x0_w;
         pix_y_d = pix_y_q + 1'b1;
      end
   end

   // NOTE: the argument buffer has no reset; a byte is always written before it is read,
   // and leaving it out of the reset network lets it map onto plain storage.
   always_ff @(posedge i_clk) begin
      if (state_q == ARGS && accept) begin
         args_q[cnt_q] <= i_data;
      end
   end

   // NOTE: all state below is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= IDLE;
         op_q        <= OP_NOOP;
         cnt_q       <= 4'd0;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
         drop_q      <= 1'b0;
         error_q     <= 1'b0;
         set_mode_q  <= 1'b0;
         set_pixel_q <= 1'b0;
         mode_q      <= '0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         color_q     <= '0;
      end else begin
         ack_q      <= accept;
         drop_q     <= offer && busy_q;
         error_q    <= 1'b0;
         set_mode_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q  <= i_data;
                  cnt_q <= 4'd0;
                  if (i_data > OP_FILL_RECT) begin
                     error_q <= 1'b1;
                  end else if (i_data == OP_NOOP) begin
                     state_q <= EXEC;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= ARGS;
                  end
               end
            end

            ARGS: begin
               if (accept) begin
                  if (cnt_q == arg_len(op_q) - 4'd1) begin
                     state_q <= (op_q == OP_FILL_RECT) ? FILL : EXEC;
                     busy_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end

            EXEC: begin
               if (!set_pixel_q) begin
                  case (op_q)
                     OP_SET_MODE: begin
                        mode_q     <= MODE_W'(args_q[0]);
                        set_mode_q <= 1'b1;
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                     end
                     OP_SET_BG_COLOR: begin
                        pix_x_q     <= '0;
                        pix_y_q     <= '0;
                        color_q     <= bg_color_w;
                        set_pixel_q <= 1'b1;
                     end
                     OP_SET_PIXEL: begin
                        pix_x_q     <= x0_w;
                        pix_y_q     <= y0_w;
                        color_q     <= px_color_w;
                        set_pixel_q <= 1'b1;
                     end
                     default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  endcase
               end else if (i_pixel_ready) begin
                  set_pixel_q <= 1'b0;
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
               end
            end

            FILL: begin
               if (!set_pixel_q) begin
                  if (fill_empty_w) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     pix_x_q     <= x0_w;
                     pix_y_q     <= y0_w;
                     color_q     <= fill_color_w;
                     set_pixel_q <= 1'b1;
                  end
               end else if (i_pixel_ready) begin
                  if (fill_last_w) begin
                     set_pixel_q <= 1'b0;
                     state_q     <= IDLE;
                     busy_q      <= 1'b0;
                  end else begin
                     pix_x_q <= pix_x_d;
                     pix_y_q <= pix_y_d;
                  end
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_ack       = ack_q;
   assign o_busy      = busy_q;
   assign o_drop      = drop_q;
   assign o_error     = error_q;
   assign o_mode      = mode_q;
   assign o_set_mode  = set_mode_q;
   assign o_pixel_x   = pix_x_q;
   assign o_pixel_y   = pix_y_q;
   assign o_color     = color_q;
   assign o_set_pixel = set_pixel_q;

endmodule

// File: tb/tb_gpu_command_decoder.sv
`timescale 1ns/1ps
// Scoreboard bench for gpu_command_decoder: directed command streams push expected
// events; a negedge monitor pops and compares each mode strobe, error and pixel write.
module tb_gpu_command_decoder;

   localparam int X_W     = 10;
   localparam int Y_W     = 10;
   localparam int COLOR_W = 12;
   localparam int MODE_W  = 8;

   logic               i_clk = 1'b0;
   logic               i_reset_n;
   logic               i_en;
   logic               i_we;
   logic [7:0]         i_data;
   logic               o_ack;
   logic               o_busy;
   logic               o_drop;
   logic               o_error;
   logic [MODE_W-1:0]  o_mode;
   logic               o_set_mode;
   logic [X_W-1:0]     o_pixel_x;
   logic [Y_W-1:0]     o_pixel_y;
   logic [COLOR_W-1:0] o_color;
   logic               o_set_pixel;
   logic               i_pixel_ready;

   gpu_command_decoder #(
      .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .MODE_W(MODE_W)
   ) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en), .i_we(i_we), .i_data(i_data),
      .o_ack(o_ack), .o_busy(o_busy), .o_drop(o_drop), .o_error(o_error),
      .o_mode(o_mode), .o_set_mode(o_set_mode), .o_pixel_x(o_pixel_x),
      .o_pixel_y(o_pixel_y), .o_color(o_color), .o_set_pixel(o_set_pixel),
      .i_pixel_ready(i_pixel_ready)
   );

   always #5 i_clk = ~i_clk;

   typedef enum int {EV_MODE, EV_PIX, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
   } ev_t;

   ev_t sb[$];
   int  total = 0;
   int  bad = 0;
   int  busy_cnt = 0;
   int  pix_hi = 0;
   int  pix_acc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_pix(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c);
      ev_t e;
      e.kind = EV_PIX; e.a = x; e.b = y; e.c = c;
      sb.push_back(e);
   endtask

   task automatic exp_ev(input ev_kind_t k, input logic [15:0] a);
      ev_t e;
      e.kind = k; e.a = a; e.b = '0; e.c = '0;
      sb.push_back(e);
   endtask

   task automatic pop_check(input ev_kind_t k, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c);
      ev_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event: got %s, expected none", k.name());
      end else begin
         e = sb.pop_front();
         check("event_kind", 32'(k), 32'(e.kind));
         if (e.kind == EV_MODE && k == EV_MODE) check("mode_value", 32'(a), 32'(e.a));
         if (e.kind == EV_PIX && k == EV_PIX) begin
            check("pixel_x", 32'(a), 32'(e.a));
            check("pixel_y", 32'(b), 32'(e.b));
            check("pixel_color", 32'(c), 32'(e.c));
         end
      end
   endtask

   // Monitor: samples on the falling edge, away from the active rising edge.
   always @(negedge i_clk) begin
      if (i_reset_n) begin
         if (o_busy) busy_cnt++;
         if (o_set_pixel) pix_hi++;
         if (o_set_mode) pop_check(EV_MODE, 16'(o_mode), '0, '0);
         if (o_error) pop_check(EV_ERR, '0, '0, '0);
         if (o_set_pixel && i_pixel_ready) begin
            pix_acc++;
            pop_check(EV_PIX, 16'(o_pixel_x), 16'(o_pixel_y), 16'(o_color));
         end
      end
   end

   // Called one time unit after a rising edge; returns one unit after the next one.
   task automatic send(input logic [7:0] b, input bit acc);
      i_en = 1'b1; i_we = 1'b1; i_data = b;
      @(posedge i_clk); #1;
      i_en = 1'b0; i_we = 1'b0;
      check($sformatf("ack_%02h", b), 32'(o_ack), 32'(acc));
      check($sformatf("drop_%02h", b), 32'(o_drop), 32'(!acc));
   endtask

   task automatic send_seq(input logic [7:0] bytes [], input int n);
      for (int i = 0; i < n; i++) send(bytes[i], 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ack"}, 32'(o_ack), 0);
      check({tag, "_busy"}, 32'(o_busy), 0);
      check({tag, "_drop"}, 32'(o_drop), 0);
      check({tag, "_error"}, 32'(o_error), 0);
      check({tag, "_mode"}, 32'(o_mode), 0);
      check({tag, "_set_mode"}, 32'(o_set_mode), 0);
      check({tag, "_pixel_x"}, 32'(o_pixel_x), 0);
      check({tag, "_pixel_y"}, 32'(o_pixel_y), 0);
      check({tag, "_color"}, 32'(o_color), 0);
      check({tag, "_set_pixel"}, 32'(o_set_pixel), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] cmd [];
      int acc0;

      i_reset_n = 1'b0; i_en = 1'b0; i_we = 1'b0; i_data = 8'h00; i_pixel_ready = 1'b0;
      #3;
      check_quiet("in_reset");
      #20;
      i_reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge i_clk); #1;
         check_quiet($sformatf("post_reset%0d", i));
      end

      // SET_MODE 0x05: strobe in the cycle after the edge that follows the last byte.
      exp_ev(EV_MODE, 16'h0005);
      send(8'h01, 1'b1);
      send(8'h05, 1'b1);
      check("mode_busy_at_E", 32'(o_busy), 1);
      check("mode_strobe_early", 32'(o_set_mode), 0);
      idle(1);
      check("mode_strobe", 32'(o_set_mode), 1);
      check("mode_value_direct", 32'(o_mode), 32'h05);
      check("mode_busy_fell", 32'(o_busy), 0);
      idle(1);
      check("mode_strobe_width", 32'(o_set_mode), 0);

      // SET_PIXEL (10,20,0xF34) held against three cycles of back-pressure.
      i_pixel_ready = 1'b0;
      exp_pix(16'd10, 16'd20, 16'hF34);
      cmd = '{8'h03, 8'h0A, 8'h00, 8'h14, 8'h00, 8'h34, 8'h0F};
      pix_hi = 0;
      send_seq(cmd, 7);
      check("px_busy_at_E", 32'(o_busy), 1);
      idle(1);
      check("px_valid", 32'(o_set_pixel), 1);
      check("px_x_direct", 32'(o_pixel_x), 10);
      check("px_y_direct", 32'(o_pixel_y), 20);
      check("px_color_direct", 32'(o_color), 32'hF34);
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      idle(1);
      check("px_held_x", 32'(o_pixel_x), 10);
      i_pixel_ready = 1'b1;
      idle(1);
      check("px_done_valid", 32'(o_set_pixel), 0);
      check("px_done_busy", 32'(o_busy), 0);
      check("px_hold_cycles", 32'(pix_hi), 4);

      // FILL_RECT (2,1)-(3,2) colour 0x0ABC, ready tied high.
      cmd = '{8'h04, 8'h02, 8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h02, 8'h00, 8'hBC, 8'h0A};
      exp_pix(16'd2, 16'd1, 16'hABC);
      exp_pix(16'd3, 16'd1, 16'hABC);
      exp_pix(16'd2, 16'd2, 16'hABC);
      exp_pix(16'd3, 16'd2, 16'hABC);
      busy_cnt = 0; pix_hi = 0;
      send_seq(cmd, 11);
      idle(8);
      check("fill_busy_cycles", 32'(busy_cnt), 5);
      check("fill_valid_cycles", 32'(pix_hi), 4);

      // Degenerate rectangle x1 < x0: nothing written.
      cmd = '{8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
      busy_cnt = 0; pix_hi = 0;
      send_seq(cmd, 11);
      idle(4);
      check("empty_busy_cycles", 32'(busy_cnt), 1);
      check("empty_valid_cycles", 32'(pix_hi), 0);

      // Boundary rectangle at x = 1023.
      cmd = '{8'h04, 8'hFF, 8'h03, 8'h07, 8'h00, 8'hFF, 8'h03, 8'h07, 8'h00, 8'h23, 8'h01};
      exp_pix(16'd1023, 16'd7, 16'h123);
      busy_cnt = 0; pix_hi = 0;
      send_seq(cmd, 11);
      idle(5);
      check("edge_busy_cycles", 32'(busy_cnt), 2);
      check("edge_valid_cycles", 32'(pix_hi), 1);
      check("edge_idle_busy", 32'(o_busy), 0);

      // Unknown opcode, then a normal SET_MODE 0x02.
      exp_ev(EV_ERR, '0);
      send(8'h7F, 1'b1);
      check("err_pulse", 32'(o_error), 1);
      check("err_no_busy", 32'(o_busy), 0);
      exp_ev(EV_MODE, 16'h0002);
      send(8'h01, 1'b1);
      check("err_pulse_width", 32'(o_error), 0);
      send(8'h02, 1'b1);
      idle(3);

      // Reset after three pixels of a 10-wide fill.
      cmd = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00};
      exp_pix(16'd0, 16'd0, 16'h0F0);
      exp_pix(16'd1, 16'd0, 16'h0F0);
      exp_pix(16'd2, 16'd0, 16'h0F0);
      acc0 = pix_acc;
      send_seq(cmd, 11);
      repeat (4) @(posedge i_clk);
      #2;
      i_reset_n = 1'b0;
      #1;
      check("rst_valid_drop", 32'(o_set_pixel), 0);
      check("rst_busy_drop", 32'(o_busy), 0);
      check("rst_pixels_written", 32'(pix_acc - acc0), 3);
      idle(2);
      i_reset_n = 1'b1;
      idle(1);
      exp_pix(16'd1, 16'd2, 16'h003);
      cmd = '{8'h03, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
      send_seq(cmd, 7);
      idle(4);
      check("post_rst_busy", 32'(o_busy), 0);

      idle(2);
      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
